sram_responder: RTL and testbench

- Responder end of the pipeline's memory request/acknowledge protocol. It serves the fetch port (instruction reads) and the data port (loads/stores) from one shared word-organised SRAM array.
- Requests are accepted one at a time with a programmable wait-state latency and acknowledged with a one-cycle ack pulse.
- Performs byte/half/word lane selection, sign extension and byte-lane store masking.
- Lets the core run against a realistic multi-cycle memory.

---
 rtl/sram_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_sram_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: shared word-organised SRAM answering the fetch and data
// request/ack ports one access at a time with a programmable wait latency.
module sram_responder #(
  parameter int    DEPTH_WORDS = 4096,
  parameter int    LATENCY     = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fe_req,
  input  logic [31:0] fe_addr,
  output logic        fe_ack,
  output logic [31:0] fe_data,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic        mem_write,
  input  logic [31:0] mem_data_in,
  input  logic        mem_extend,
  input  logic [1:0]  mem_width,
  output logic        mem_ack,
  output logic [31:0] mem_data_out,
  output logic        misalign_err,
  output logic [31:0] misalign_addr
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT_FE, WAIT_MEM, ACK} state_t;

  state_t state, state_next;

  logic [31:0] mem_array [DEPTH_WORDS];

  logic [3:0]  wait_cnt;
  logic [31:0] lat_addr;
  logic        lat_write;
  logic [1:0]  lat_width;
  logic        lat_extend;
  logic [31:0] lat_wdata;
  logic        owner_mem;

  logic        accept;
  logic        waiting;
  logic        acc_fire;
  logic        acc_mem;
  logic        acc_write;
  logic        acc_extend;
  logic [1:0]  acc_width;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [AW-1:0] acc_idx;
  logic        acc_misaligned;
  logic [31:0] rd_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_result;
  logic [3:0]  store_be;
  logic [31:0] store_lanes;
  logic        store_en;

  assign accept  = (state == IDLE) && (mem_req || fe_req);
  assign waiting = (state == WAIT_FE) || (state == WAIT_MEM);

  // Pick the access operands: live inputs while idle (only used directly at zero latency), latched copies otherwise.
  always_comb begin
    if (state == IDLE) begin
      acc_mem    = mem_req;
      acc_addr   = mem_req ? mem_addr : fe_addr;
      acc_write  = mem_req & mem_write;
      acc_width  = mem_width;
      acc_extend = mem_extend;
      acc_wdata  = mem_data_in;
    end else begin
      acc_mem    = owner_mem;
      acc_addr   = lat_addr;
      acc_write  = lat_write;
      acc_width  = lat_width;
      acc_extend = lat_extend;
      acc_wdata  = lat_wdata;
    end
  end

  // The access happens on the edge that moves the FSM into ACK, so the wait phase spans exactly LATENCY cycles.
  always_comb begin
    acc_fire = ((LATENCY == 0) && accept) || (waiting && (wait_cnt <= 4'd1));
  end

  assign acc_idx = acc_addr[AW+1:2];
  assign rd_word = mem_array[acc_idx];

  // Half accesses need bit 0 clear, word (and reserved) accesses need both low bits clear.
  always_comb begin
    acc_misaligned = 1'b0;
    if (acc_mem) begin
      case (acc_width)
        2'd0:    acc_misaligned = 1'b0;
        2'd1:    acc_misaligned = acc_addr[0];
        default: acc_misaligned = (acc_addr[1:0] != 2'b00);
      endcase
    end
  end

  // Lane selection and sign/zero extension for loads; stores and misaligned accesses return zero.
  always_comb begin
    byte_sel    = 8'h00;
    half_sel    = 16'h0000;
    load_result = 32'h0000_0000;
    case (acc_addr[1:0])
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_width)
      2'd0:    load_result = {{24{acc_extend & byte_sel[7]}}, byte_sel};
      2'd1:    load_result = {{16{acc_extend & half_sel[15]}}, half_sel};
      default: load_result = rd_word;
    endcase
    if (acc_write || acc_misaligned) load_result = 32'h0000_0000;
  end

  // Byte-lane enables and replicated store data so each enabled lane sees its right-justified source bits.
  always_comb begin
    store_be    = 4'b0000;
    store_lanes = acc_wdata;
    case (acc_width)
      2'd0: begin
        store_be    = 4'b0001 << acc_addr[1:0];
        store_lanes = {4{acc_wdata[7:0]}};
      end
      2'd1: begin
        store_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{acc_wdata[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_lanes = acc_wdata;
      end
    endcase
  end

  assign store_en = acc_fire & acc_mem & acc_write & ~acc_misaligned;

  // Array write port; state resets to IDLE asynchronously so an aborted store never reaches this point.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (store_be[lane]) mem_array[acc_idx][8*lane +: 8] <= store_lanes[8*lane +: 8];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state: data port wins arbitration; ACK always returns to IDLE without arbitrating.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mem_req)     state_next = (LATENCY == 0) ? ACK : WAIT_MEM;
        else if (fe_req) state_next = (LATENCY == 0) ? ACK : WAIT_FE;
        else             state_next = IDLE;
      end
      WAIT_FE, WAIT_MEM: begin
        if (acc_fire) state_next = ACK;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: only the port that owns the finished access sees its ack, and only in ACK.
  always_comb begin
    fe_ack  = (state == ACK) && !owner_mem;
    mem_ack = (state == ACK) && owner_mem;
  end

  // Request latching, wait counter, result registers and the sticky misalignment record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt      <= 4'd0;
      lat_addr      <= 32'h0000_0000;
      lat_write     <= 1'b0;
      lat_width     <= 2'd0;
      lat_extend    <= 1'b0;
      lat_wdata     <= 32'h0000_0000;
      owner_mem     <= 1'b0;
      fe_data       <= 32'h0000_0000;
      mem_data_out  <= 32'h0000_0000;
      misalign_err  <= 1'b0;
      misalign_addr <= 32'h0000_0000;
    end else begin
      if (accept) begin
        lat_addr   <= acc_addr;
        lat_write  <= acc_write;
        lat_width  <= acc_width;
        lat_extend <= acc_extend;
        lat_wdata  <= acc_wdata;
        owner_mem  <= mem_req;
        wait_cnt   <= LAT_LOAD;
      end else if (waiting && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (acc_fire) begin
        if (acc_mem) begin
          mem_data_out <= load_result;
          if (acc_misaligned) begin
            misalign_err <= 1'b1;
            if (!misalign_err) misalign_addr <= acc_addr;
          end
        end else begin
          fe_data <= rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: randomized and directed checks of sram_responder against a
// word-array reference model of the memory and the protocol timing.
module tb_sram_responder;

  localparam int LAT    = 2;
  localparam int ACK_AT = LAT + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fe_req = 1'b0;
  logic [31:0] fe_addr = 32'h0;
  logic        fe_ack;
  logic [31:0] fe_data;
  logic        mem_req = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_data_in = 32'h0;
  logic        mem_extend = 1'b0;
  logic [1:0]  mem_width = 2'd0;
  logic        mem_ack;
  logic [31:0] mem_data_out;
  logic        misalign_err;
  logic [31:0] misalign_addr;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [4096];

  sram_responder #(.DEPTH_WORDS(4096), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_ack(fe_ack), .fe_data(fe_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_data_in(mem_data_in), .mem_extend(mem_extend), .mem_width(mem_width),
    .mem_ack(mem_ack), .mem_data_out(mem_data_out),
    .misalign_err(misalign_err), .misalign_addr(misalign_addr)
  );

  always #5 clk = ~clk;

  // Overall time guard in case a bounded wait itself is broken.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd4096);
  endfunction

  function automatic bit model_misaligned(input logic [31:0] a, input logic [1:0] w);
    if (w == 2'd0) return 1'b0;
    if (w == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] w, input bit ext);
    logic [31:0] word;
    logic [31:0] v;
    int sh;
    word = model_mem[widx(a)];
    if (model_misaligned(a, w)) return 32'h0;
    if (w == 2'd0) begin
      sh = 8 * int'(a % 4);
      v  = (word >> sh) & 32'hFF;
      if (ext && v >= 32'h80) v = v - 32'h100;
    end else if (w == 2'd1) begin
      sh = 16 * int'((a % 4) / 2);
      v  = (word >> sh) & 32'hFFFF;
      if (ext && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    int nbytes;
    int first;
    logic [31:0] word;
    logic [31:0] b;
    if (model_misaligned(a, w)) return;
    nbytes = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    first  = (nbytes == 4) ? 0 : int'(a % 4);
    word   = model_mem[widx(a)];
    for (int i = 0; i < nbytes; i++) begin
      b    = (d >> (8 * i)) & 32'hFF;
      word = (word & ~(32'hFF << (8 * (first + i)))) | (b << (8 * (first + i)));
    end
    model_mem[widx(a)] = word;
  endtask

  // ---------------- transaction drivers (entered in IDLE, #1 after an edge) ----------------
  task automatic mem_txn(input logic [31:0] a, input bit wr, input logic [1:0] w, input bit ext,
                         input logic [31:0] d, output logic [31:0] rdata, output int lat, output bit other_ack);
    mem_addr = a; mem_write = wr; mem_width = w; mem_extend = ext; mem_data_in = d; mem_req = 1'b1;
    lat = -1; rdata = 32'h0; other_ack = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (fe_ack) other_ack = 1'b1;
      if (mem_ack) begin
        lat   = c;
        rdata = mem_data_out;
      end
    end
    mem_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic fe_txn(input logic [31:0] a, output logic [31:0] rdata, output int lat, output bit other_ack);
    fe_addr = a; fe_req = 1'b1;
    lat = -1; rdata = 32'h0; other_ack = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (mem_ack) other_ack = 1'b1;
      if (fe_ack) begin
        lat   = c;
        rdata = fe_data;
      end
    end
    fe_req = 1'b0;
    @(posedge clk); #1;
  endtask

  // Store a word through the DUT and mirror it in the model.
  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int lat;
    bit oth;
    mem_txn(a, 1'b1, 2'd2, 1'b0, d, r, lat, oth);
    model_store(a, 2'd2, d);
    total++;
    if (lat !== ACK_AT) begin bad++; $display("[TB] FAIL preload_lat @%h: got %0d want %0d", a, lat, ACK_AT); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (fe_ack !== 1'b0)        begin bad++; $display("[TB] FAIL reset_fe_ack: got %b want 0", fe_ack); end
    total++; if (mem_ack !== 1'b0)       begin bad++; $display("[TB] FAIL reset_mem_ack: got %b want 0", mem_ack); end
    total++; if (fe_data !== 32'h0)      begin bad++; $display("[TB] FAIL reset_fe_data: got %h want 0", fe_data); end
    total++; if (mem_data_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_data: got %h want 0", mem_data_out); end
    total++; if (misalign_err !== 1'b0)  begin bad++; $display("[TB] FAIL reset_mis_err: got %b want 0", misalign_err); end
    total++; if (misalign_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_mis_addr: got %h want 0", misalign_addr); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_latency;
    logic exp_ack;
    preload(32'h100, 32'h0000_0013);
    fe_addr = 32'h100; fe_req = 1'b1;
    total++; if (fe_ack !== 1'b0) begin bad++; $display("[TB] FAIL fetch_ack_c0: got %b want 0", fe_ack); end
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      exp_ack = (c == ACK_AT);
      total++;
      if (fe_ack !== exp_ack) begin bad++; $display("[TB] FAIL fetch_ack_c%0d: got %b want %b", c, fe_ack, exp_ack); end
      if (c == ACK_AT) begin
        total++;
        if (fe_data !== model_mem[widx(32'h100)]) begin
          bad++; $display("[TB] FAIL fetch_data: got %h want %h", fe_data, model_mem[widx(32'h100)]);
        end
        fe_req = 1'b0;
      end
    end
  endtask

  task automatic test_priority;
    logic exp_m, exp_f;
    preload(32'h200, 32'hDEAD_BEEF);
    preload(32'h000, 32'h0000_0093);
    mem_addr = 32'h200; mem_write = 1'b0; mem_width = 2'd2; mem_extend = 1'b0; mem_req = 1'b1;
    fe_addr = 32'h0; fe_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      exp_m = (c == ACK_AT);
      exp_f = (c == 2 * ACK_AT + 1);
      total++;
      if (mem_ack !== exp_m || fe_ack !== exp_f) begin
        bad++; $display("[TB] FAIL prio_acks_c%0d: got mem=%b fe=%b want mem=%b fe=%b", c, mem_ack, fe_ack, exp_m, exp_f);
      end
      if (c == ACK_AT) begin
        total++;
        if (mem_data_out !== model_load(32'h200, 2'd2, 1'b0)) begin
          bad++; $display("[TB] FAIL prio_mem_data: got %h want %h", mem_data_out, model_load(32'h200, 2'd2, 1'b0));
        end
        mem_req = 1'b0;
      end
      if (c == 2 * ACK_AT + 1) begin
        total++;
        if (fe_data !== model_mem[widx(32'h0)]) begin
          bad++; $display("[TB] FAIL prio_fe_data: got %h want %h", fe_data, model_mem[widx(32'h0)]);
        end
        fe_req = 1'b0;
      end
    end
  endtask

  // Run one data access, update the model and compare result, latency and the silent port.
  task automatic test_data_access(input string tag, input logic [31:0] a, input bit wr, input logic [1:0] w,
                                  input bit ext, input logic [31:0] d);
    logic [31:0] r, exp;
    int lat;
    bit oth;
    exp = wr ? 32'h0 : model_load(a, w, ext);
    mem_txn(a, wr, w, ext, d, r, lat, oth);
    if (wr) model_store(a, w, d);
    total++;
    if (r !== exp || lat !== ACK_AT || oth !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s @%h: got data=%h lat=%0d fe_ack_seen=%b want data=%h lat=%0d fe_ack_seen=0",
               tag, a, r, lat, oth, exp, ACK_AT);
    end
  endtask

  task automatic test_byte_lanes;
    preload(32'h200, 32'h1122_3344);
    test_data_access("st_byte",     32'h203, 1'b1, 2'd0, 1'b0, 32'hFFFF_FFAB);
    test_data_access("ld_word_ab",  32'h200, 1'b0, 2'd2, 1'b0, 32'h0);
    total++;
    if (model_mem[widx(32'h200)] !== 32'hAB22_3344) begin
      bad++; $display("[TB] FAIL model_byte_merge: got %h want ab223344", model_mem[widx(32'h200)]);
    end
    test_data_access("ld_byte_sx",  32'h203, 1'b0, 2'd0, 1'b1, 32'h0);
    test_data_access("ld_byte_zx",  32'h203, 1'b0, 2'd0, 1'b0, 32'h0);
  endtask

  task automatic test_half;
    preload(32'h200, 32'h8001_1234);
    test_data_access("ld_half_sx",  32'h202, 1'b0, 2'd1, 1'b1, 32'h0);
    test_data_access("ld_half_zx",  32'h202, 1'b0, 2'd1, 1'b0, 32'h0);
    test_data_access("st_half",     32'h200, 1'b1, 2'd1, 1'b0, 32'hCAFE_5566);
    test_data_access("ld_word_h",   32'h200, 1'b0, 2'd2, 1'b0, 32'h0);
  endtask

  task automatic test_misalign;
    preload(32'h200, 32'h0BAD_F00D);
    test_data_access("st_word_mis", 32'h201, 1'b1, 2'd2, 1'b0, 32'h1234_5678);
    total++; if (misalign_err !== 1'b1) begin bad++; $display("[TB] FAIL mis_err_set: got %b want 1", misalign_err); end
    total++; if (misalign_addr !== 32'h201) begin bad++; $display("[TB] FAIL mis_addr_first: got %h want 00000201", misalign_addr); end
    test_data_access("ld_after_mis", 32'h200, 1'b0, 2'd2, 1'b0, 32'h0);
    preload(32'h300, 32'hFFFF_FFFF);
    test_data_access("ld_half_mis", 32'h303, 1'b0, 2'd1, 1'b1, 32'h0);
    total++; if (misalign_addr !== 32'h201) begin bad++; $display("[TB] FAIL mis_addr_sticky: got %h want 00000201", misalign_addr); end
    total++; if (misalign_err !== 1'b1) begin bad++; $display("[TB] FAIL mis_err_sticky: got %b want 1", misalign_err); end
  endtask

  task automatic test_random;
    logic [31:0] a, r, exp;
    int lat;
    bit oth;
    for (int i = 0; i < 16; i++) preload(32'h400 + 32'(4 * i), $urandom);
    for (int n = 0; n < 60; n++) begin
      a = ($urandom & 32'hFFFF_C000) | 32'h400 | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) begin
        exp = model_mem[widx(a)];
        fe_txn(a, r, lat, oth);
        total++;
        if (r !== exp || lat !== ACK_AT || oth !== 1'b0) begin
          bad++; $display("[TB] FAIL rnd_fetch @%h: got data=%h lat=%0d mem_ack_seen=%b want data=%h lat=%0d",
                          a, r, lat, oth, exp, ACK_AT);
        end
      end else begin
        test_data_access("rnd_data", a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), $urandom);
      end
    end
    total++; if (misalign_addr !== 32'h201) begin bad++; $display("[TB] FAIL rnd_mis_addr: got %h want 00000201", misalign_addr); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] r;
    int lat;
    bit oth;
    preload(32'h40, 32'h5A5A_0F0F);
    mem_addr = 32'h40; mem_write = 1'b1; mem_width = 2'd2; mem_data_in = 32'hA5A5_F0F0; mem_req = 1'b1;
    @(posedge clk); #1;
    total++; if (mem_ack !== 1'b0) begin bad++; $display("[TB] FAIL abort_wait_ack: got %b want 0", mem_ack); end
    reset = 1'b1; mem_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++; if (mem_ack !== 1'b0) begin bad++; $display("[TB] FAIL abort_rst_ack_c%0d: got %b want 0", c, mem_ack); end
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      total++;
      if (mem_ack !== 1'b0 || fe_ack !== 1'b0) begin
        bad++; $display("[TB] FAIL abort_post_acks_c%0d: got mem=%b fe=%b want 0 0", c, mem_ack, fe_ack);
      end
    end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL abort_mis_clear: got %b want 0", misalign_err); end
    fe_txn(32'h40, r, lat, oth);
    total++;
    if (r !== model_mem[widx(32'h40)] || lat !== ACK_AT) begin
      bad++; $display("[TB] FAIL abort_fetch: got data=%h lat=%0d want data=%h lat=%0d", r, lat, model_mem[widx(32'h40)], ACK_AT);
    end
    test_data_access("abort_ld_word", 32'h40, 1'b0, 2'd2, 1'b0, 32'h0);
  endtask

  // Run all scenarios in order and report.
  initial begin
    test_reset();
    test_fetch_latency();
    test_priority();
    test_byte_lanes();
    test_half();
    test_misalign();
    test_random();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
